// File: rtl/mac_pkg.sv
// Shared definitions for the mac_stream block.
//   MAC_DWIDTH    default operand width per lane
//   MAC_LANES     default number of multiplier lanes per beat
//   frame_state_t frame tracking state at the accumulate stage
package mac_pkg;

    localparam int MAC_DWIDTH = 8;
    localparam int MAC_LANES  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_t;

endpackage

// File: rtl/mac_lane_sum.sv
// Registered multiply + adder-tree stage (S2) of mac_stream.
// Multiplies LANES operand pairs (signed or unsigned per beat) and sums
// them into an ACC_W-bit value, registered when en is high.
//   clk, reset          clock, synchronous active-high reset
//   en                  stage advance (low while the result port stalls)
//   vld, last           beat valid / frame-last flag from S1
//   is_signed, sat      per-beat mode bits from S1 (passed through)
//   a, b                packed lane operands
//   sum_vld, sum_last   registered valid / last
//   sum_signed, sum_sat registered mode bits
//   sum                 registered sum of products
module mac_lane_sum import mac_pkg::*; #(
    parameter int DWIDTH = MAC_DWIDTH,
    parameter int LANES  = MAC_LANES,
    parameter int ACC_W  = 3 * DWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     vld,
    input  logic                     last,
    input  logic                     is_signed,
    input  logic                     sat,
    input  logic [LANES*DWIDTH-1:0]  a,
    input  logic [LANES*DWIDTH-1:0]  b,
    output logic                     sum_vld,
    output logic                     sum_last,
    output logic                     sum_signed,
    output logic                     sum_sat,
    output logic [ACC_W-1:0]         sum
);

    // One extra bit per operand lets a single signed multiplier serve both
    // modes: unsigned operands are zero-extended, signed ones sign-extended.
    localparam int PW    = 2 * DWIDTH + 2;
    localparam int NODES = 2 * LANES - 1;

    // Heap-ordered adder tree: node n sums nodes 2n+1 and 2n+2,
    // leaves sit at LANES-1 .. 2*LANES-2. Requires LANES a power of 2.
    logic signed [ACC_W-1:0] node [NODES];

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            logic signed [DWIDTH:0] ea, eb;
            logic signed [PW-1:0]   prod;
            assign ea   = {is_signed & a[i*DWIDTH+DWIDTH-1], a[i*DWIDTH +: DWIDTH]};
            assign eb   = {is_signed & b[i*DWIDTH+DWIDTH-1], b[i*DWIDTH +: DWIDTH]};
            assign prod = PW'(ea) * PW'(eb);
            assign node[LANES-1+i] = ACC_W'(prod);
        end
        for (i = 0; i < LANES - 1; i++) begin : g_tree
            assign node[i] = node[2*i+1] + node[2*i+2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_vld    <= 1'b0;
            sum_last   <= 1'b0;
            sum_signed <= 1'b0;
            sum_sat    <= 1'b0;
            sum        <= '0;
        end else if (en) begin
            sum_vld    <= vld;
            sum_last   <= last;
            sum_signed <= is_signed;
            sum_sat    <= sat;
            sum        <= node[0];
        end
    end

endmodule

// File: rtl/mac_stream.sv
// Streaming multi-lane multiply-accumulate. Each accepted beat contributes
// the dot product of its lanes to a frame accumulator; the frame result is
// presented on the m_* port after the s_last beat completes.
// Pipeline: S1 input register, S2 multiply/adder tree, S3 accumulate.
//   clk, reset           clock, synchronous active-high reset
//   cfg_signed, cfg_sat  mode, latched on the first beat of each frame
//   s_valid/s_ready      input beat handshake
//   s_a, s_b, s_last     packed lane operands, frame-last flag
//   m_valid/m_ready      result handshake
//   m_data, m_ovf        frame result, sticky overflow/saturation flag
module mac_stream import mac_pkg::*; #(
    parameter int DWIDTH = MAC_DWIDTH,
    parameter int LANES  = MAC_LANES,
    parameter int ACC_W  = 3 * DWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_signed,
    input  logic                     cfg_sat,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [LANES*DWIDTH-1:0]  s_a,
    input  logic [LANES*DWIDTH-1:0]  s_b,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ACC_W-1:0]         m_data,
    output logic                     m_ovf
);

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

    // A pending result that is not taken freezes the whole pipeline.
    logic adv, s_fire;
    assign adv     = !(m_valid && !m_ready);
    assign s_ready = adv;
    assign s_fire  = s_valid && adv;

    // Input-side frame tracking: mode is captured on the first beat and
    // travels with every beat of the frame, so later cfg changes are ignored.
    logic first_beat, lat_signed, lat_sat, beat_signed, beat_sat;
    assign beat_signed = first_beat ? cfg_signed : lat_signed;
    assign beat_sat    = first_beat ? cfg_sat    : lat_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            first_beat <= 1'b1;
            lat_signed <= 1'b0;
            lat_sat    <= 1'b0;
        end else if (s_fire) begin
            first_beat <= s_last;
            if (first_beat) begin
                lat_signed <= cfg_signed;
                lat_sat    <= cfg_sat;
            end
        end
    end

    // S1
    logic                    s1_vld, s1_last, s1_signed, s1_sat;
    logic [LANES*DWIDTH-1:0] s1_a, s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            s1_sat    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
        end else if (adv) begin
            s1_vld    <= s_valid;
            s1_last   <= s_last;
            s1_signed <= beat_signed;
            s1_sat    <= beat_sat;
            s1_a      <= s_a;
            s1_b      <= s_b;
        end
    end

    // S2
    logic             s2_vld, s2_last, s2_signed, s2_sat;
    logic [ACC_W-1:0] s2_sum;

    mac_lane_sum #(
        .DWIDTH (DWIDTH),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .clk        (clk),
        .reset      (reset),
        .en         (adv),
        .vld        (s1_vld),
        .last       (s1_last),
        .is_signed  (s1_signed),
        .sat        (s1_sat),
        .a          (s1_a),
        .b          (s1_b),
        .sum_vld    (s2_vld),
        .sum_last   (s2_last),
        .sum_signed (s2_signed),
        .sum_sat    (s2_sat),
        .sum        (s2_sum)
    );

    // S3 frame FSM
    frame_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (adv && s2_vld)
            state_next = s2_last ? ST_IDLE : ST_ACCUM;
    end

    // S3 accumulate. The add is done one bit wider so overflow is exact:
    // signed overflows when the two top bits disagree, unsigned on carry out.
    logic [ACC_W-1:0] acc, base, add_res, clamp;
    logic [ACC_W:0]   wide;
    logic             ovf_acc, add_ovf;

    assign base = (state == ST_IDLE) ? '0 : acc;

    always_comb begin
        wide    = '0;
        add_ovf = 1'b0;
        clamp   = UMAX;
        if (s2_signed) begin
            wide    = {base[ACC_W-1], base} + {s2_sum[ACC_W-1], s2_sum};
            add_ovf = wide[ACC_W] ^ wide[ACC_W-1];
            clamp   = wide[ACC_W] ? SMIN : SMAX;
        end else begin
            wide    = {1'b0, base} + {1'b0, s2_sum};
            add_ovf = wide[ACC_W];
        end
        add_res = (add_ovf && s2_sat) ? clamp : wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ovf   <= 1'b0;
        end else if (adv) begin
            if (s2_vld && s2_last) begin
                m_data  <= add_res;
                m_ovf   <= ovf_acc | add_ovf;
                m_valid <= 1'b1;
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else begin
                // adv with m_valid high implies m_ready: the result is taken
                m_valid <= 1'b0;
                if (s2_vld) begin
                    acc     <= add_res;
                    ovf_acc <= ovf_acc | add_ovf;
                end
            end
        end
    end

endmodule

// File: doc/mac_stream.md
MAC_STREAM -- requirements
Module: mac_stream

Interface
REQ-001 Parameter DWIDTH, default 8, operand width per lane.
REQ-002 Parameter LANES, default 4, parallel multiplier lanes per beat (power of 2, >=1).
REQ-003 Parameter ACC_W, default 3*DWIDTH, accumulator and result width (>= 2*DWIDTH + clog2(LANES)).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on the first beat of a frame.
REQ-007 cfg_sat  input  1  1 = saturate accumulator at ACC_W limits, 0 = wrap; sampled on the first beat of a frame.
REQ-008 s_valid  input  1  input beat valid.
REQ-009 s_ready  output  1  block accepts the beat.
REQ-010 s_a  input  LANES*DWIDTH  lane operands A, lane i at bits [i*DWIDTH +: DWIDTH].
REQ-011 s_b  input  LANES*DWIDTH  lane operands B, same packing.
REQ-012 s_last  input  1  final beat of a dot-product frame.
REQ-013 m_valid  output  1  result valid.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 m_data  output  ACC_W  frame result.
REQ-016 m_ovf  output  1  sticky: overflow or saturation occurred in this frame.

Function
REQ-017 Beat transfer occurs when s_valid && s_ready on a rising edge; result transfer when m_valid && m_ready.
REQ-018 Pipeline: S1 registers s_a/s_b/s_last/mode; S2 computes sum over lanes of a_i*b_i (sign-extended to ACC_W per mode); S3 adds to accumulator.
REQ-019 Latency: m_valid rises on the 3rd rising edge after (and counting) the edge accepting the s_last beat, absent stall.
REQ-020 Throughput: one beat per cycle with no bubbles while m_ready stays high.
REQ-021 stall = m_valid && !m_ready; while stall, S1, S2, S3, accumulator and m_data/m_ovf hold; s_ready = !stall.
REQ-022 m_data and m_ovf remain stable while m_valid && !m_ready.
REQ-023 Frame FSM states IDLE, ACCUM: IDLE -> ACCUM on a non-last S3 beat; ACCUM -> IDLE on a last S3 beat; a last beat in IDLE (single-beat frame) stays in IDLE.
REQ-024 On the last S3 beat: m_data <= acc + sum, m_ovf updated with that add, m_valid <= 1, acc <= 0, overflow flag <= 0 in the same edge.
REQ-025 m_valid clears on the edge where m_ready is high and no new last beat completes S3; a new last completing on the same edge keeps m_valid high with new data.
REQ-026 Mode (cfg_signed, cfg_sat) latched on the first beat of a frame and applied to every beat of that frame; changes mid-frame are ignored.
REQ-027 Wrap mode: acc is modulo 2^ACC_W; m_ovf set if true result differs from the ACC_W result (signed or unsigned per mode).
REQ-028 Sat mode: on overflow acc clamps to max (unsigned 2^ACC_W-1, signed 2^(ACC_W-1)-1) or signed min -2^(ACC_W-1), stays clamped only if later adds keep it out of range, m_ovf sticky.
REQ-029 Unsigned sat: results below zero are impossible; no underflow clamp.

Reset
REQ-030 Reset clears all pipeline valids, acc, FSM (IDLE), latched mode; m_valid=0, m_data=0, m_ovf=0; s_ready=1 the cycle after reset deasserts.
REQ-031 Reset mid-frame or while a result is pending discards all partial and pending data; no result is emitted.

Structure
REQ-032 Shared package mac_pkg holds the frame-state enum and default DWIDTH/LANES constants (defaults mirror the existing DWIDTH define).
REQ-033 One sub-module mac_lane_sum (registered S2 multiply and adder tree, signed/unsigned) is instantiated once.

Verification (DWIDTH=8, LANES=4, ACC_W=24)
REQ-034 Single-beat frame, unsigned, a={1,2,3,4}, b={5,6,7,8}, last=1 -> m_data=70 three edges later, m_ovf=0.
REQ-035 Signed 2-beat frame a={-1,-2,0,0}, b={3,4,0,0} twice -> m_data=-22 (0xFFFFEA), m_ovf=0.
REQ-036 Unsigned, 300 beats all lanes 255*255, cfg_sat=1 -> m_data=0xFFFFFF, m_ovf=1; same with cfg_sat=0 -> m_data=(300*260100) mod 2^24, m_ovf=1.
REQ-037 Back-to-back single-beat frames with m_ready low 5 cycles -> s_ready low, m_data held, no frames lost or reordered after release.
REQ-038 Reset asserted mid-frame after 3 beats, then 1-beat frame {1,1,1,1}x{1,1,1,1} -> m_data=4, no earlier result emitted.
REQ-039 cfg_signed toggled mid-frame -> result computed in the mode latched on the frame's first beat.
